// File: rtl/rv32m_csa_mul_sequencer_if.sv
// rtl/rv32m_csa_mul_sequencer_if.sv - issue/result bundle between RV32M decode and the multiplier sequencer
interface rv32m_csa_mul_sequencer_if #(
   parameter int BIT_WIDTH = 32
);
   logic                     start;
   logic                     flush;
   logic [BIT_WIDTH-1:0]     multiplicand;
   logic [BIT_WIDTH-1:0]     multiplier;
   logic [1:0]               is_signed;
   logic                     busy;
   logic                     finished;
   logic [2*BIT_WIDTH-1:0]   product;

   // Issue side: decode/issue logic drives requests, observes status and result
   modport master (
      output start, flush, multiplicand, multiplier, is_signed,
      input  busy, finished, product
   );

   // Sequencer side
   modport slave (
      input  start, flush, multiplicand, multiplier, is_signed,
      output busy, finished, product
   );
endinterface

// File: rtl/rv32m_csa_mul_sequencer.sv
// rtl/rv32m_csa_mul_sequencer.sv - iterative radix-2 carry-save multiplier sequencer for RV32M
module rv32m_csa_mul_sequencer #(
   parameter int BIT_WIDTH = 32
) (
   input logic                      CLK,
   input logic                      RST,
   rv32m_csa_mul_sequencer_if.slave bus
);
   localparam int N  = BIT_WIDTH;
   localparam int KW = (N > 2) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

   state_t          state;
   logic [N-1:0]    a_mag;
   logic [N-1:0]    b_mag;
   logic            neg;
   logic [2*N-1:0]  sum_q;
   logic [2*N-1:0]  carry_q;
   logic [KW-1:0]   k;
   logic            busy_q;
   logic            finished_q;
   logic [2*N-1:0]  product_q;

   logic            a_in_neg;
   logic            b_in_neg;
   logic [N-1:0]    a_in_mag;
   logic [N-1:0]    b_in_mag;
   logic [2*N-1:0]  pp;
   logic [2*N-1:0]  csa_sum;
   logic [2*N-1:0]  csa_carry;
   logic [2*N-1:0]  mag;
   logic            accept;

   assign bus.busy     = busy_q;
   assign bus.finished = finished_q;
   assign bus.product  = product_q;

   // Operand magnitudes, partial product, 3:2 compression and final carry-propagate add
   always_comb begin
      a_in_neg  = bus.is_signed[1] & bus.multiplicand[N-1];
      b_in_neg  = bus.is_signed[0] & bus.multiplier[N-1];
      a_in_mag  = a_in_neg ? (~bus.multiplicand + 1'b1) : bus.multiplicand;
      b_in_mag  = b_in_neg ? (~bus.multiplier + 1'b1) : bus.multiplier;
      pp        = '0;
      if (b_mag[k]) begin
         pp = {{N{1'b0}}, a_mag} << k;
      end
      csa_sum   = sum_q ^ carry_q ^ pp;
      // carry out of the top bit is dropped; the true product always fits in 2N bits
      csa_carry = ((sum_q & carry_q) | (sum_q & pp) | (carry_q & pp)) << 1;
      mag       = sum_q + carry_q;
      accept    = bus.start & ~bus.flush;
   end

   // Sequencer FSM with registered busy/finished and product holding register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         a_mag      <= '0;
         b_mag      <= '0;
         neg        <= 1'b0;
         sum_q      <= '0;
         carry_q    <= '0;
         k          <= '0;
         busy_q     <= 1'b0;
         finished_q <= 1'b0;
         product_q  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               finished_q <= 1'b0;
               if (accept) begin
                  a_mag   <= a_in_mag;
                  b_mag   <= b_in_mag;
                  neg     <= a_in_neg ^ b_in_neg;
                  sum_q   <= '0;
                  carry_q <= '0;
                  k       <= '0;
                  busy_q  <= 1'b1;
                  state   <= ACCUM;
               end else begin
                  busy_q  <= 1'b0;
                  state   <= IDLE;
               end
            end
            ACCUM: begin
               if (bus.flush) begin
                  busy_q <= 1'b0;
                  k      <= '0;
                  state  <= IDLE;
               end else begin
                  sum_q   <= csa_sum;
                  carry_q <= csa_carry;
                  if (k == K_LAST) begin
                     k     <= '0;
                     state <= RESOLVE;
                  end else begin
                     k     <= k + 1'b1;
                  end
               end
            end
            RESOLVE: begin
               busy_q <= 1'b0;
               if (bus.flush) begin
                  state <= IDLE;
               end else begin
                  product_q  <= neg ? (~mag + 1'b1) : mag;
                  finished_q <= 1'b1;
                  state      <= DONE;
               end
            end
            default: begin
               busy_q     <= 1'b0;
               finished_q <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule
